norm_shift_seq: RTL
===================

NORM_SHIFT_SEQ -- requirements
Module: norm_shift_seq

Interface
REQ-001 The block SHALL have parameter MANT_W, default 24: mantissa width including the hidden bit.
REQ-002 The block SHALL have parameter EXP_W, default 8: biased exponent width.
REQ-003 The block SHALL have parameter STEP, default 4: maximum left shift applied per cycle, with 1 <= STEP <= MANT_W.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: an input operand is present.
REQ-007 The block SHALL have port IN_READY, output, 1 bit: the block can accept an operand.
REQ-008 The block SHALL have port IN, input, MANT_W bits: the unnormalised mantissa.
REQ-009 The block SHALL have port INOF, input, 1 bit: the mantissa carried out of its MSB.
REQ-010 The block SHALL have port IN_EXP, input, EXP_W bits: the biased exponent.
REQ-011 The block SHALL have port IN_SIGN, input, 1 bit: the sign, passed through.
REQ-012 The block SHALL have port OUT_VALID, output, 1 bit: a result is present.
REQ-013 The block SHALL have port OUT_READY, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port OUT, output, MANT_W-1 bits: the fraction with the hidden bit removed.
REQ-015 The block SHALL have port OUT_EXP, output, EXP_W bits: the adjusted biased exponent.
REQ-016 The block SHALL have port OUT_SIGN, output, 1 bit: the sign.
REQ-017 The block SHALL have port COUNT, output, CNT_W = clog2(MANT_W)+2 bits, two's complement: the total exponent adjustment.
REQ-018 The block SHALL have ports ZEROFLAG, UFLAG and OFLAG, each an output of 1 bit: zero result, denormal result and exponent overflow respectively.

Function
REQ-019 The FSM SHALL have three states: IDLE, SHIFT and DONE; IN_READY SHALL be 1 only in IDLE, and OUT_VALID SHALL be 1 only in DONE.
REQ-020 Accept SHALL occur when IN_VALID=1 and IN_READY=1; the operand is registered on that edge.
REQ-021 When INOF=1, the accept edge SHALL set OUT=IN[MANT_W-1:1], OUT_EXP=IN_EXP+1 and COUNT=+1, then go to DONE.
REQ-022 When INOF=1 and IN_EXP+1 = all-ones, or IN_EXP is already all-ones, the result SHALL instead be OUT=0, OUT_EXP=all-ones, OFLAG=1.
REQ-023 When INOF=0 and IN=0, the result SHALL be OUT=0, OUT_EXP=0, COUNT=-MANT_W and ZEROFLAG=1, going to DONE.
REQ-024 Otherwise, IN_EXP=0 SHALL be treated as 1; shift target s = min(lz(IN), E-1), where E is the effective exponent.
REQ-025 If s=0, the block SHALL go directly to DONE; otherwise it SHALL go to SHIFT.
REQ-026 Each SHIFT cycle SHALL shift left by min(remaining, STEP), shifting in zeros, and decrement the working exponent by the same amount.
REQ-027 SHIFT SHALL go to DONE on the edge completing s.
REQ-028 On finishing, a mantissa with MSB=1 SHALL give OUT=mant[MANT_W-2:0] and OUT_EXP=working exponent; a mantissa with MSB=0 SHALL give OUT_EXP=0 and UFLAG=1.
REQ-029 COUNT SHALL equal -s for all non-INOF, non-zero results.
REQ-030 Latency from the accept edge to OUT_VALID SHALL be 1 cycle for the INOF, zero and s=0 cases, and 1+ceil(s/STEP) cycles otherwise.
REQ-031 DONE SHALL hold all outputs stable until OUT_READY=1; the handoff edge SHALL return to IDLE, with no accept in the same cycle.
REQ-032 OUT_SIGN SHALL equal the IN_SIGN captured at accept, including for zero results.
REQ-033 At most one of ZEROFLAG, UFLAG and OFLAG SHALL be set.
REQ-034 Outside DONE, OUT, OUT_EXP, COUNT and the flags SHALL be 0.

Reset
REQ-035 RST=1 SHALL force state IDLE on the next edge from any state, discarding any in-flight operand.
REQ-036 After reset, IN_READY SHALL be 1, OUT_VALID 0, and all other outputs 0.
REQ-037 RST SHALL take priority over accept and handoff in the same cycle.

Structure
REQ-038 Package norm_pkg SHALL hold the state encoding, the default MANT_W/EXP_W/STEP values and the CNT_W function.
REQ-039 Sub-module lzc SHALL be a parametrised combinational leading-zero counter of width MANT_W, used for s and for the SHIFT amounts.

Verification
REQ-040 Scenario, defaults: IN=0x800000, IN_EXP=127 -> OUT_VALID after 1 cycle, OUT=0, OUT_EXP=127, COUNT=0.
REQ-041 Scenario: IN=0x000001, IN_EXP=127 -> OUT_VALID after 7 cycles, OUT=0, OUT_EXP=104, COUNT=-23.
REQ-042 Scenario: INOF=1, IN=0x000003, IN_EXP=10 -> OUT=0x000001, OUT_EXP=11, COUNT=+1; a second operand with INOF=1, IN_EXP=254 -> OFLAG=1, OUT_EXP=255, OUT=0.
REQ-043 Scenario: IN=0x010000, IN_EXP=3 -> after 2 cycles UFLAG=1, OUT_EXP=0, OUT=0x040000, COUNT=-2.
REQ-044 Scenario: IN=0, IN_EXP=50, IN_SIGN=1 -> after 1 cycle ZEROFLAG=1, OUT_EXP=0, OUT_SIGN=1, COUNT=-24.
REQ-045 Scenario: OUT_READY held low 5 cycles in DONE -> outputs stable and IN_READY=0; RST pulsed during SHIFT -> next cycle IDLE with OUT_VALID=0 and IN_READY=1.

Source files
------------

// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
// norm_pkg : shared defaults, FSM encoding and width helper for norm_shift_seq
// Revision : 1.0
// ============================================================================
package norm_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;
    localparam int STEP_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Two's-complement width wide enough to hold -MANT_W .. +1
    function automatic int cnt_w(input int mant_w);
        return $clog2(mant_w) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/norm_shift_seq_lzc.sv
`default_nettype none
// ============================================================================
// lzc : combinational leading-zero counter; an all-zero input reports W
// Revision : 1.0
// ============================================================================
module lzc #(
    parameter int W    = 24,
    parameter int LZ_W = $clog2(W + 1)
) (
    input  logic [W-1:0]    i_data,
    output logic [LZ_W-1:0] o_count
);

    // Scanning upward lets the highest set bit win
    always_comb begin
        o_count = LZ_W'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = LZ_W'(W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/norm_shift_seq.sv
`default_nettype none
// ============================================================================
// norm_shift_seq : multi-cycle mantissa normaliser, at most STEP bits per cycle
// Revision : 1.0
// ============================================================================
module norm_shift_seq
    import norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int STEP   = STEP_DEF,
    localparam int CNT_W = cnt_w(MANT_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [MANT_W-1:0] IN,
    input  logic              INOF,
    input  logic [EXP_W-1:0]  IN_EXP,
    input  logic              IN_SIGN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [MANT_W-2:0] OUT,
    output logic [EXP_W-1:0]  OUT_EXP,
    output logic              OUT_SIGN,
    output logic [CNT_W-1:0]  COUNT,
    output logic              ZEROFLAG,
    output logic              UFLAG,
    output logic              OFLAG
);

    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam int TW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam logic [EXP_W-1:0] C_EXP_MAX = '1;
    localparam logic [EXP_W-1:0] C_EXP_OVF = {{(EXP_W-1){1'b1}}, 1'b0};

    state_t             r_state;
    logic [MANT_W-1:0]  r_mant;
    logic [EXP_W-1:0]   r_exp;
    logic               r_sign;
    logic [CNT_W-1:0]   r_cnt;

    logic [MANT_W-1:0]  w_lz_in;
    logic [LZ_W-1:0]    w_lz;
    logic [EXP_W-1:0]   w_e_eff;
    logic [TW-1:0]      w_e_m1;
    logic [TW-1:0]      w_target;
    logic [TW-1:0]      w_amt;
    logic [MANT_W-1:0]  w_mant_sh;
    logic [EXP_W-1:0]   w_exp_sh;
    logic [MANT_W-1:0]  w_fin_mant;
    logic [EXP_W-1:0]   w_fin_exp;
    logic               w_fin_norm;

    lzc #(
        .W    (MANT_W),
        .LZ_W (LZ_W)
    ) u_lzc (
        .i_data  (w_lz_in),
        .o_count (w_lz)
    );

    // Remaining shift is recomputed from the working mantissa each cycle,
    // so no separate down-counter is needed.
    always_comb begin
        w_lz_in    = (r_state == ST_IDLE) ? IN : r_mant;
        w_e_eff    = (r_state == ST_IDLE) ? ((IN_EXP == '0) ? EXP_W'(1) : IN_EXP) : r_exp;
        w_e_m1     = TW'(w_e_eff) - TW'(1);
        w_target   = (TW'(w_lz) < w_e_m1) ? TW'(w_lz) : w_e_m1;
        w_amt      = (w_target > TW'(STEP)) ? TW'(STEP) : w_target;
        w_mant_sh  = r_mant << w_amt;
        w_exp_sh   = r_exp - EXP_W'(w_amt);
        w_fin_mant = (r_state == ST_IDLE) ? IN : w_mant_sh;
        w_fin_exp  = (r_state == ST_IDLE) ? w_e_eff : w_exp_sh;
        w_fin_norm = w_fin_mant[MANT_W-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            r_mant    <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_cnt     <= '0;
            OUT       <= '0;
            OUT_EXP   <= '0;
            OUT_SIGN  <= 1'b0;
            COUNT     <= '0;
            ZEROFLAG  <= 1'b0;
            UFLAG     <= 1'b0;
            OFLAG     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        IN_READY <= 1'b0;
                        if (INOF) begin
                            r_state   <= ST_DONE;
                            OUT_VALID <= 1'b1;
                            OUT_SIGN  <= IN_SIGN;
                            COUNT     <= CNT_W'(1);
                            if (IN_EXP >= C_EXP_OVF) begin
                                OUT_EXP <= C_EXP_MAX;
                                OFLAG   <= 1'b1;
                            end else begin
                                OUT     <= IN[MANT_W-1:1];
                                OUT_EXP <= IN_EXP + EXP_W'(1);
                            end
                        end else if (IN == '0) begin
                            r_state   <= ST_DONE;
                            OUT_VALID <= 1'b1;
                            OUT_SIGN  <= IN_SIGN;
                            COUNT     <= -CNT_W'(MANT_W);
                            ZEROFLAG  <= 1'b1;
                        end else if (w_target == '0) begin
                            r_state   <= ST_DONE;
                            OUT_VALID <= 1'b1;
                            OUT_SIGN  <= IN_SIGN;
                            OUT       <= w_fin_mant[MANT_W-2:0];
                            OUT_EXP   <= w_fin_norm ? w_fin_exp : '0;
                            UFLAG     <= ~w_fin_norm;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_mant  <= IN;
                            r_exp   <= w_e_eff;
                            r_sign  <= IN_SIGN;
                            r_cnt   <= -CNT_W'(w_target);
                        end
                    end
                end
                ST_SHIFT: begin
                    r_mant <= w_mant_sh;
                    r_exp  <= w_exp_sh;
                    if (w_target == w_amt) begin
                        r_state   <= ST_DONE;
                        OUT_VALID <= 1'b1;
                        OUT_SIGN  <= r_sign;
                        COUNT     <= r_cnt;
                        OUT       <= w_fin_mant[MANT_W-2:0];
                        OUT_EXP   <= w_fin_norm ? w_fin_exp : '0;
                        UFLAG     <= ~w_fin_norm;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        r_state   <= ST_IDLE;
                        IN_READY  <= 1'b1;
                        OUT_VALID <= 1'b0;
                        OUT       <= '0;
                        OUT_EXP   <= '0;
                        OUT_SIGN  <= 1'b0;
                        COUNT     <= '0;
                        ZEROFLAG  <= 1'b0;
                        UFLAG     <= 1'b0;
                        OFLAG     <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    IN_READY  <= 1'b1;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
